// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared state encoding, symbol constants and default widths
package genius_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int BTN_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_CHECK        = 3'd3,
        ST_DONE         = 3'd4,
        ST_FAIL         = 3'd5
    } state_e;

    localparam logic [3:0] SYM_G = 4'b0001;
    localparam logic [3:0] SYM_R = 4'b0010;
    localparam logic [3:0] SYM_Y = 4'b0100;
    localparam logic [3:0] SYM_B = 4'b1000;

endpackage

// File: rtl/user_seq_checker_if.sv
// rtl/user_seq_checker_if.sv - controller/store/button bundle for the sequence checker
interface user_seq_checker_if #(
    parameter int IDX_W = 4,
    parameter int BTN_W = 4
);
    logic             E;
    logic [IDX_W-1:0] level;
    logic [BTN_W-1:0] btn;
    logic [BTN_W-1:0] exp_sym;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] SEQUSR;
    logic             busy;
    logic             tc;
    logic             err;
    logic             tmo;

    modport master (
        output E, level, btn, exp_sym,
        input  rd_idx, SEQUSR, busy, tc, err, tmo
    );

    modport slave (
        input  E, level, btn, exp_sym,
        output rd_idx, SEQUSR, busy, tc, err, tmo
    );
endinterface

// File: rtl/btn_press_tracker.sv
// rtl/btn_press_tracker.sv - one-hot press qualification, pressed latch, release detection
module btn_press_tracker #(
    parameter int BTN_W = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic [BTN_W-1:0] btn,
    input  logic             capture,
    output logic             press_valid,
    output logic             press_bad,
    output logic             release_ok,
    output logic             release_bad,
    output logic [BTN_W-1:0] pressed
);
    logic [BTN_W-1:0] pressed_q;
    logic [BTN_W-1:0] pressed_d;

    always_comb begin
        pressed_d = pressed_q;
        if (capture) begin
            pressed_d = btn;
        end
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end

    // Any change away from the latched button other than a full release is a chord.
    assign press_valid = $onehot(btn);
    assign press_bad   = (btn != '0) && !$onehot(btn);
    assign release_ok  = (btn == '0);
    assign release_bad = (btn != '0) && (btn != pressed_q);
    assign pressed     = pressed_q;
endmodule

// File: rtl/user_seq_checker.sv
// rtl/user_seq_checker.sv - player press checker FSM; optional press timeout via GENIUS_TIMEOUT_EN
module user_seq_checker
    import genius_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int BTN_W = BTN_W_DEF
`ifdef GENIUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 50000000
`endif
) (
    input  logic          clk,
    input  logic          R,
    user_seq_checker_if.slave bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] seq_q, seq_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             capture;
    logic             press_valid, press_bad, release_ok, release_bad;
    logic [BTN_W-1:0] pressed;

`ifdef GENIUS_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tmo_q, tmo_d;
`endif

    btn_press_tracker #(.BTN_W(BTN_W)) u_tracker (
        .clk         (clk),
        .R           (R),
        .btn         (bus.btn),
        .capture     (capture),
        .press_valid (press_valid),
        .press_bad   (press_bad),
        .release_ok  (release_ok),
        .release_bad (release_bad),
        .pressed     (pressed)
    );

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        seq_d    = seq_q;
        busy_d   = busy_q;
        tc_d     = tc_q;
        err_d    = err_q;
        capture  = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
        timer_d  = timer_q;
        tmo_d    = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.E) begin
                    state_d  = ST_WAIT_PRESS;
                    rd_idx_d = '0;
                    seq_d    = '0;
                    busy_d   = 1'b1;
                    tc_d     = 1'b0;
                    err_d    = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
                    timer_d  = '0;
                    tmo_d    = 1'b0;
`endif
                end
            end
            ST_WAIT_PRESS: begin
                if (!bus.E) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (press_bad) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (press_valid) begin
                    state_d = ST_WAIT_RELEASE;
                    capture = 1'b1;
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ST_WAIT_RELEASE: begin
                if (!bus.E) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (release_ok) begin
                    state_d = ST_CHECK;
                end else if (release_bad) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_CHECK: begin
                if (!bus.E) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (pressed != bus.exp_sym) begin
                    state_d = ST_FAIL;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // Saturate so a full 2^IDX_W round reports the max count instead of wrapping.
                    seq_d = (seq_q == '1) ? seq_q : seq_q + 1'b1;
                    if (rd_idx_q == bus.level) begin
                        state_d = ST_DONE;
                        tc_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = ST_WAIT_PRESS;
                        rd_idx_d = rd_idx_q + 1'b1;
`ifdef GENIUS_TIMEOUT_EN
                        timer_d  = '0;
`endif
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                if (!bus.E) begin
                    state_d = ST_IDLE;
                    tc_d    = 1'b0;
                    err_d   = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            seq_q    <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
            timer_q  <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            seq_q    <= seq_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
`ifdef GENIUS_TIMEOUT_EN
            timer_q  <= timer_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.rd_idx = rd_idx_q;
    assign bus.SEQUSR = seq_q;
    assign bus.busy   = busy_q;
    assign bus.tc     = tc_q;
    assign bus.err    = err_q;
`ifdef GENIUS_TIMEOUT_EN
    assign bus.tmo    = tmo_q;
`else
    assign bus.tmo    = 1'b0;
`endif
endmodule

// File: tb/tb_user_seq_checker.sv
// tb/tb_user_seq_checker.sv - directed scoreboard bench for user_seq_checker
module tb_user_seq_checker;
    import genius_pkg::*;

    typedef struct {
        logic [3:0] seq;
        logic       tc;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       R   = 1'b0;
    logic [3:0] mem [16];
    exp_t       sb [$];
    int         vectors = 0;
    int         miscompares = 0;

    user_seq_checker_if #(.IDX_W(4), .BTN_W(4)) bus ();

    user_seq_checker #(
        .IDX_W(4),
        .BTN_W(4)
`ifdef GENIUS_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.exp_sym = mem[bus.rd_idx];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_tc"},   32'(bus.tc),   32'd0);
        check({tag, "_err"},  32'(bus.err),  32'd0);
        check({tag, "_tmo"},  32'(bus.tmo),  32'd0);
    endtask

    task automatic press(input string tag, input logic [3:0] sym,
                         input logic [3:0] eseq, input logic etc, input logic eerr);
        exp_t e;
        e.seq = eseq; e.tc = etc; e.err = eerr;
        sb.push_back(e);
        bus.btn = sym;
        tick(3);
        bus.btn = 4'b0;
        tick(2);
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_seq"}, 32'(bus.SEQUSR), 32'(e.seq));
            check({tag, "_tc"},  32'(bus.tc),     32'(e.tc));
            check({tag, "_err"}, 32'(bus.err),    32'(e.err));
        end
    endtask

    initial begin
        bus.E = 1'b0; bus.level = 4'd0; bus.btn = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = SYM_G;

        // reset state
        tick(2);
        check("rst_rd_idx", 32'(bus.rd_idx), 32'd0);
        check("rst_seq",    32'(bus.SEQUSR), 32'd0);
        check_idle_outputs("rst");
        R = 1'b1;
        tick(1);

        // 1: three correct presses
        bus.level = 4'd2;
        mem[0] = SYM_G; mem[1] = SYM_R; mem[2] = SYM_Y;
        bus.E = 1'b1;
        tick(1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        press("t1_p0", SYM_G, 4'd1, 1'b0, 1'b0);
        press("t1_p1", SYM_R, 4'd2, 1'b0, 1'b0);
        press("t1_p2", SYM_Y, 4'd3, 1'b1, 1'b0);
        check("t1_busy_done", 32'(bus.busy), 32'd0);
        bus.E = 1'b0;
        tick(1);
        check("t1_tc_clr", 32'(bus.tc), 32'd0);

        // 2: wrong symbol at index 1
        bus.level = 4'd3;
        mem[0] = SYM_G; mem[1] = SYM_R; mem[2] = SYM_Y; mem[3] = SYM_B;
        bus.E = 1'b1;
        tick(1);
        press("t2_p0", SYM_G, 4'd1, 1'b0, 1'b0);
        press("t2_p1", SYM_B, 4'd1, 1'b0, 1'b1);
        bus.E = 1'b0;
        tick(1);
        check("t2_err_clr", 32'(bus.err), 32'd0);

        // 3: ambiguous press and chord while held
        bus.E = 1'b1;
        tick(1);
        bus.btn = 4'b0101;
        tick(1);
        check("t3_multi_err", 32'(bus.err), 32'd1);
        bus.btn = 4'b0; bus.E = 1'b0;
        tick(1);
        bus.E = 1'b1;
        tick(1);
        bus.btn = SYM_G;
        tick(1);
        bus.btn = 4'b0011;
        tick(1);
        check("t3_chord_err", 32'(bus.err), 32'd1);
        check("t3_chord_tc",  32'(bus.tc),  32'd0);
        bus.btn = 4'b0; bus.E = 1'b0;
        tick(1);

        // 4: abort mid-round, restart clears counters
        bus.E = 1'b1;
        tick(1);
        press("t4_p0", SYM_G, 4'd1, 1'b0, 1'b0);
        check("t4_rd_idx", 32'(bus.rd_idx), 32'd1);
        bus.E = 1'b0;
        tick(1);
        check_idle_outputs("t4_abort");
        bus.E = 1'b1;
        tick(1);
        check("t4_seq_restart", 32'(bus.SEQUSR), 32'd0);
        check("t4_idx_restart", 32'(bus.rd_idx), 32'd0);
        bus.E = 1'b0;
        tick(1);

        // 5a: reset while a button is held
        bus.E = 1'b1;
        tick(1);
        press("t5_p0", SYM_G, 4'd1, 1'b0, 1'b0);
        bus.btn = SYM_R;
        tick(1);
        R = 1'b0;
        tick(1);
        check("t5_rst_seq", 32'(bus.SEQUSR), 32'd0);
        check("t5_rst_idx", 32'(bus.rd_idx), 32'd0);
        check_idle_outputs("t5_rst");
        bus.E = 1'b0; bus.btn = 4'b0; R = 1'b1;
        tick(1);

        // 5b: full 16-press round saturates SEQUSR at 15
        bus.level = 4'd15;
        for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
        bus.E = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            press($sformatf("t5_full%0d", i), mem[i],
                  (i < 15) ? 4'(i + 1) : 4'd15, (i == 15), 1'b0);
        end
        check("t5_full_idx", 32'(bus.rd_idx), 32'd15);
        bus.E = 1'b0;
        tick(1);

        // level=0: one press completes
        bus.level = 4'd0;
        mem[0] = SYM_B;
        bus.E = 1'b1;
        tick(1);
        press("lvl0", SYM_B, 4'd1, 1'b1, 1'b0);
        bus.E = 1'b0;
        tick(1);

`ifdef GENIUS_TIMEOUT_EN
        // 6: idle timeout and long hold
        bus.E = 1'b1;
        tick(1);
        tick(5);
        check("t6_no_err_early", 32'(bus.err), 32'd0);
        tick(4);
        check("t6_tmo_err", 32'(bus.err), 32'd1);
        check("t6_tmo",     32'(bus.tmo), 32'd1);
        bus.E = 1'b0;
        tick(1);
        check("t6_tmo_clr", 32'(bus.tmo), 32'd0);
        bus.level = 4'd0;
        mem[0] = SYM_G;
        bus.E = 1'b1;
        tick(1);
        bus.btn = SYM_G;
        tick(20);
        check("t6_hold_err", 32'(bus.err), 32'd0);
        bus.btn = 4'b0;
        tick(2);
        check("t6_hold_tc", 32'(bus.tc), 32'd1);
        bus.E = 1'b0;
        tick(1);
`else
        // without the timer a long wait never errors
        bus.E = 1'b1;
        tick(30);
        check("wait_err",  32'(bus.err),  32'd0);
        check("wait_tmo",  32'(bus.tmo),  32'd0);
        check("wait_busy", 32'(bus.busy), 32'd1);
        bus.E = 1'b0;
        tick(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
